// File: rtl/cim_accum_if.sv
// rtl/cim_accum_if.sv - handshake bundle for the compute-in-memory tile accumulator
//
// Groups the PE-tile input stream, the memory-tile input stream, the result
// output stream and the mismatch status signals.
//   slave  : the accumulator side (consumes PE/mem beats, produces results)
//   master : the environment side (drives PE/mem beats, consumes results)
interface cim_accum_if #(
  parameter int TILE  = 6,
  parameter int DW    = 12,
  parameter int AW    = 8,
  parameter int BUS_W = 512
);
  logic [TILE*TILE*DW-1:0] pe_tile_i;
  logic [AW-1:0]           pe_addr_i;
  logic                    pe_valid_i;
  logic                    pe_ready_o;

  logic [BUS_W-1:0]        mem_data_i;
  logic [AW-1:0]           mem_addr_i;
  logic                    mem_valid_i;
  logic                    mem_ready_o;

  logic [BUS_W-1:0]        result_o;
  logic [AW-1:0]           result_addr_o;
  logic                    result_valid_o;
  logic                    result_ready_i;

  logic                    mismatch_o;
  logic [7:0]              err_cnt_o;

  modport slave (
    input  pe_tile_i, pe_addr_i, pe_valid_i,
    output pe_ready_o,
    input  mem_data_i, mem_addr_i, mem_valid_i,
    output mem_ready_o,
    output result_o, result_addr_o, result_valid_o,
    input  result_ready_i,
    output mismatch_o, err_cnt_o
  );

  modport master (
    output pe_tile_i, pe_addr_i, pe_valid_i,
    input  pe_ready_o,
    output mem_data_i, mem_addr_i, mem_valid_i,
    input  mem_ready_o,
    input  result_o, result_addr_o, result_valid_o,
    output result_ready_i,
    input  mismatch_o, err_cnt_o
  );
endinterface

// File: rtl/cim_accum.sv
// rtl/cim_accum.sv - pairs buffered PE tiles with memory tiles by address and emits element-wise sums
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : cim_accum_if.slave (PE stream in, memory stream in, result stream out,
//            mismatch pulse and saturating 8-bit mismatch counter)
// Optional feature: define CIM_ACCUM_SAT_EN to clamp each element sum to the
// signed DW range; otherwise sums wrap modulo 2^DW.
module cim_accum #(
  parameter int TILE  = 6,
  parameter int DW    = 12,
  parameter int AW    = 8,
  parameter int BUS_W = 512,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  cim_accum_if.slave bus
);
  localparam int NE = TILE * TILE;
  localparam int TW = NE * DW;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (TW > BUS_W) begin : g_bus_chk
    $error("cim_accum: TILE*TILE*DW must not exceed BUS_W");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("cim_accum: DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic {EMPTY, FULL} res_state_t;

  res_state_t       state, state_next;
  logic [TW-1:0]    tile_q [DEPTH];
  logic [AW-1:0]    addr_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic [TW-1:0]    head_tile;
  logic [AW-1:0]    head_addr;
  logic             push, mem_acc, hit, miss;
  logic [BUS_W-1:0] sum_bus;
  logic signed [DW:0] s;
  logic             unused_msb;
  logic             unused_bits;
  logic [BUS_W-1:0] result_q;
  logic [AW-1:0]    result_addr_q;
  logic             mismatch_q;
  logic [7:0]       err_cnt_q;

  assign head_tile = tile_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];

  // Ready depends only on registered occupancy, so a full buffer never
  // accepts a beat even when the head is being popped in the same cycle.
  assign bus.pe_ready_o  = (count < (PW+1)'(DEPTH));
  assign bus.mem_ready_o = (count != '0) && (state == EMPTY || bus.result_ready_i);

  assign push    = bus.pe_valid_i && bus.pe_ready_o;
  assign mem_acc = bus.mem_valid_i && bus.mem_ready_o;
  assign hit     = mem_acc && (bus.mem_addr_i == head_addr);
  assign miss    = mem_acc && !hit;

  // Only the tile-sized low part of the memory bus carries data.
  assign unused_bits = ^bus.mem_data_i;

  always_ff @(posedge clk) begin
    if (push) begin
      tile_q[wr_ptr] <= bus.pe_tile_i;
      addr_q[wr_ptr] <= bus.pe_addr_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (hit)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, hit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Element-wise head + mem sums, one DW+1 bit adder per element.
  always_comb begin
    sum_bus    = '0;
    s          = '0;
    unused_msb = 1'b0;
    for (int k = 0; k < NE; k++) begin
      s = $signed({head_tile[k*DW+DW-1], head_tile[k*DW +: DW]})
        + $signed({bus.mem_data_i[k*DW+DW-1], bus.mem_data_i[k*DW +: DW]});
`ifdef CIM_ACCUM_SAT_EN
      // Carry and sign bits disagree only on overflow; the carry gives the direction.
      if (s[DW] != s[DW-1])
        sum_bus[k*DW +: DW] = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
        sum_bus[k*DW +: DW] = s[DW-1:0];
`else
      sum_bus[k*DW +: DW] = s[DW-1:0];
      unused_msb = unused_msb ^ s[DW];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (hit) state_next = FULL;
      FULL:    if (bus.result_ready_i && !hit) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q      <= '0;
      result_addr_q <= '0;
      mismatch_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      if (hit) begin
        result_q      <= sum_bus;
        result_addr_q <= head_addr;
      end
      mismatch_q <= miss;
      if (miss && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.result_o       = result_q;
  assign bus.result_addr_o  = result_addr_q;
  assign bus.result_valid_o = (state == FULL);
  assign bus.mismatch_o     = mismatch_q;
  assign bus.err_cnt_o      = err_cnt_q;
endmodule

// File: tb/tb_cim_accum.sv
// tb/tb_cim_accum.sv - self-checking bench for cim_accum against a queue-based reference model
module tb_cim_accum;
  localparam int TILE  = 6;
  localparam int DW    = 12;
  localparam int AW    = 8;
  localparam int BUS_W = 512;
  localparam int DEPTH = 4;
  localparam int NE    = TILE * TILE;
  localparam int TW    = NE * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cim_accum_if #(.TILE(TILE), .DW(DW), .AW(AW), .BUS_W(BUS_W)) bus ();

  cim_accum #(.TILE(TILE), .DW(DW), .AW(AW), .BUS_W(BUS_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [TW-1:0] tile;
    logic [AW-1:0] addr;
  } pend_t;

  pend_t            q[$];
  logic             m_valid = 1'b0;
  logic [BUS_W-1:0] m_data  = '0;
  logic [AW-1:0]    m_addr  = '0;
  logic             m_mis   = 1'b0;
  int               m_err   = 0;
  bit               md_pr, md_mr, md_acc, md_hit;

  function automatic logic [BUS_W-1:0] model_sum(input logic [TW-1:0] a, input logic [BUS_W-1:0] b);
    logic [BUS_W-1:0] r;
    int lo, hi, x, y, sm;
    r  = '0;
    lo = -(1 << (DW - 1));
    hi = (1 << (DW - 1)) - 1;
    for (int k = 0; k < NE; k++) begin
      x  = int'($signed(a[k*DW +: DW]));
      y  = int'($signed(b[k*DW +: DW]));
      sm = x + y;
`ifdef CIM_ACCUM_SAT_EN
      if (sm > hi) sm = hi;
      if (sm < lo) sm = lo;
`else
      if (sm > hi) sm = sm - (1 << DW);
      if (sm < lo) sm = sm + (1 << DW);
`endif
      r[k*DW +: DW] = DW'(sm);
    end
    return r;
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_addr  = '0;
    m_mis   = 1'b0;
    m_err   = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      md_pr  = q.size() < DEPTH;
      md_mr  = q.size() > 0 && (!m_valid || bus.result_ready_i);
      md_acc = bus.mem_valid_i && md_mr;
      md_hit = md_acc && (bus.mem_addr_i == q[0].addr);
      if (md_hit) begin
        m_data  = model_sum(q[0].tile, bus.mem_data_i);
        m_addr  = q[0].addr;
        m_valid = 1'b1;
        void'(q.pop_front());
      end else if (m_valid && bus.result_ready_i) begin
        m_valid = 1'b0;
      end
      m_mis = md_acc && !md_hit;
      if (m_mis && m_err < 255) m_err++;
      if (bus.pe_valid_i && md_pr) q.push_back('{bus.pe_tile_i, bus.pe_addr_i});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("pe_ready", bus.pe_ready_o, q.size() < DEPTH);
      chk("mem_ready", bus.mem_ready_o, q.size() > 0 && (!m_valid || bus.result_ready_i));
      chk("result_valid", bus.result_valid_o, m_valid);
      chk("mismatch", bus.mismatch_o, m_mis);
      chk("err_cnt", bus.err_cnt_o, m_err);
      if (m_valid) begin
        chk("result_data", bus.result_o, m_data);
        chk("result_addr", bus.result_addr_o, m_addr);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [TW-1:0] fill(input int v);
    logic [TW-1:0] r;
    for (int k = 0; k < NE; k++) r[k*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_elem();
    int sel;
    sel = $urandom % 8;
    if (sel == 0) return {1'b0, {(DW-1){1'b1}}};
    if (sel == 1) return {1'b1, {(DW-1){1'b0}}};
    return DW'($urandom);
  endfunction

  function automatic logic [BUS_W-1:0] rnd_mem();
    logic [BUS_W-1:0] r;
    for (int w = 0; w < BUS_W / 32; w++) r[w*32 +: 32] = $urandom;
    for (int k = 0; k < NE; k++) r[k*DW +: DW] = rnd_elem();
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [TW-1:0]    t;
  logic [BUS_W-1:0] m;

  initial begin
    rst_n              = 1'b0;
    bus.pe_tile_i      = '0;
    bus.pe_addr_i      = '0;
    bus.pe_valid_i     = 1'b0;
    bus.mem_data_i     = '0;
    bus.mem_addr_i     = '0;
    bus.mem_valid_i    = 1'b0;
    bus.result_ready_i = 1'b1;
    tick();
    chk("rst_result_valid", bus.result_valid_o, 0);
    chk("rst_result", bus.result_o, 0);
    chk("rst_result_addr", bus.result_addr_o, 0);
    chk("rst_pe_ready", bus.pe_ready_o, 1);
    chk("rst_mem_ready", bus.mem_ready_o, 0);
    chk("rst_err_cnt", bus.err_cnt_o, 0);
    chk("rst_mismatch", bus.mismatch_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic match: 5 + 7 = 12 everywhere
    bus.pe_tile_i = fill(5); bus.pe_addr_i = 8'h10; bus.pe_valid_i = 1'b1;
    tick();
    bus.pe_valid_i = 1'b0;
    chk("basic_mem_ready", bus.mem_ready_o, 1);
    bus.mem_data_i = {{(BUS_W-TW){1'b0}}, fill(7)}; bus.mem_addr_i = 8'h10; bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
    chk("basic_valid", bus.result_valid_o, 1);
    chk("basic_addr", bus.result_addr_o, 8'h10);
    chk("basic_e0", bus.result_o[0 +: DW], DW'(12));
    chk("basic_e35", bus.result_o[(NE-1)*DW +: DW], DW'(12));
    chk("basic_upper", bus.result_o[BUS_W-1:TW], '0);
    tick();

    // overflow at both ends of the signed range
    t = '0; t[0 +: DW] = 12'h7FF; t[DW +: DW] = 12'h800;
    m = '0; m[0 +: DW] = 12'h001; m[DW +: DW] = 12'hFFF;
    bus.pe_tile_i = t; bus.pe_addr_i = 8'h11; bus.pe_valid_i = 1'b1;
    tick();
    bus.pe_valid_i = 1'b0;
    bus.mem_data_i = m; bus.mem_addr_i = 8'h11; bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_valid_i = 1'b0;
`ifdef CIM_ACCUM_SAT_EN
    chk("ovf_pos", bus.result_o[0 +: DW], 12'h7FF);
    chk("ovf_neg", bus.result_o[DW +: DW], 12'h800);
`else
    chk("ovf_pos", bus.result_o[0 +: DW], 12'h800);
    chk("ovf_neg", bus.result_o[DW +: DW], 12'h7FF);
`endif
    tick();

    // mismatch keeps the head, then a matching beat pops it
    bus.pe_tile_i = fill(1); bus.pe_addr_i = 8'h03; bus.pe_valid_i = 1'b1;
    tick();
    bus.pe_valid_i = 1'b0;
    bus.mem_data_i = {{(BUS_W-TW){1'b0}}, fill(2)}; bus.mem_addr_i = 8'h04; bus.mem_valid_i = 1'b1;
    tick();
    chk("mis_pulse", bus.mismatch_o, 1);
    chk("mis_cnt1", bus.err_cnt_o, 1);
    chk("mis_no_result", bus.result_valid_o, 0);
    bus.mem_addr_i = 8'h03;
    tick();
    bus.mem_valid_i = 1'b0;
    chk("mis_pulse_end", bus.mismatch_o, 0);
    chk("mis_match_addr", bus.result_addr_o, 8'h03);
    chk("mis_match_e0", bus.result_o[0 +: DW], DW'(3));
    tick();

    // 300 mismatches saturate the counter
    bus.pe_tile_i = fill(0); bus.pe_addr_i = 8'h09; bus.pe_valid_i = 1'b1;
    tick();
    bus.pe_valid_i = 1'b0;
    bus.mem_addr_i = 8'h0A; bus.mem_valid_i = 1'b1;
    repeat (300) tick();
    chk("mis_sat", bus.err_cnt_o, 255);
    bus.mem_addr_i = 8'h09;
    tick();
    bus.mem_valid_i = 1'b0;
    tick();

    // backpressure: fill the buffer, stall the result, then drain in order
    bus.result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.pe_tile_i = fill(i + 1); bus.pe_addr_i = AW'(8'h20 + i); bus.pe_valid_i = 1'b1;
      tick();
    end
    bus.pe_valid_i = 1'b0;
    chk("bp_full", bus.pe_ready_o, 0);
    bus.mem_data_i = {{(BUS_W-TW){1'b0}}, fill(1)}; bus.mem_addr_i = 8'h20; bus.mem_valid_i = 1'b1;
    tick();
    bus.mem_addr_i = 8'h21;
    repeat (3) tick();
    chk("bp_mem_stall", bus.mem_ready_o, 0);
    chk("bp_hold_addr", bus.result_addr_o, 8'h20);
    chk("bp_hold_e0", bus.result_o[0 +: DW], DW'(2));
    bus.result_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      bus.mem_addr_i = AW'(8'h20 + i);
      tick();
      chk("bp_order", bus.result_addr_o, 8'h20 + i);
    end
    bus.mem_valid_i = 1'b0;
    tick();
    chk("bp_drained", bus.result_valid_o, 0);

    // asynchronous reset with pending tiles and a full result register
    bus.result_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pe_tile_i = fill(i); bus.pe_addr_i = AW'(8'h40 + i); bus.pe_valid_i = 1'b1;
      tick();
    end
    bus.pe_valid_i = 1'b0;
    bus.mem_addr_i = 8'h40; bus.mem_valid_i = 1'b1;
    tick();
    chk("mr_full", bus.result_valid_o, 1);
    bus.mem_addr_i = 8'h41;
    #3 rst_n = 1'b0;
    #1;
    chk("mr_valid", bus.result_valid_o, 0);
    chk("mr_result", bus.result_o, 0);
    chk("mr_addr", bus.result_addr_o, 0);
    chk("mr_pe_ready", bus.pe_ready_o, 1);
    chk("mr_mem_ready", bus.mem_ready_o, 0);
    chk("mr_err", bus.err_cnt_o, 0);
    chk("mr_mis", bus.mismatch_o, 0);
    bus.result_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_no_accept", bus.result_valid_o, 0);
    chk("mr_no_mis", bus.mismatch_o, 0);
    bus.mem_valid_i = 1'b0;
    tick();

    // randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      bus.pe_valid_i = ($urandom % 3) != 0;
      for (int k = 0; k < NE; k++) bus.pe_tile_i[k*DW +: DW] = rnd_elem();
      bus.pe_addr_i  = AW'($urandom);
      bus.mem_valid_i = $urandom % 2;
      bus.mem_data_i  = rnd_mem();
      if (q.size() > 0 && ($urandom % 4) != 0) bus.mem_addr_i = q[0].addr;
      else bus.mem_addr_i = AW'($urandom);
      bus.result_ready_i = ($urandom % 4) != 0;
      tick();
    end
    bus.pe_valid_i  = 1'b0;
    bus.mem_valid_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cim_accum.md
CIM_ACCUM -- requirements
Module: cim_accum

Interface
REQ-001 SHALL have parameter TILE, default 6, meaning tile edge; a tile holds TILE*TILE elements.
REQ-002 SHALL have parameter DW, default 12, meaning signed element width.
REQ-003 SHALL have parameter AW, default 8, meaning tile address width.
REQ-004 SHALL have parameter BUS_W, default 512, meaning memory/result bus width; TILE*TILE*DW<=BUS_W, elaboration-time error otherwise.
REQ-005 SHALL have parameter DEPTH, default 4, meaning pending-PE-tile buffer depth (power of 2, >=2).
REQ-006 SHALL have port clk, input, 1 bit, meaning the only clock (rising edge).
REQ-007 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-008 SHALL have pe_tile_i (input, TILE*TILE*DW, packed PE tile), pe_addr_i (input, AW), pe_valid_i (input, 1) and pe_ready_o (output, 1).
REQ-009 SHALL have mem_data_i (input, BUS_W), mem_addr_i (input, AW), mem_valid_i (input, 1) and mem_ready_o (output, 1).
REQ-010 SHALL have result_o (output, BUS_W), result_addr_o (output, AW), result_valid_o (output, 1) and result_ready_i (input, 1).
REQ-011 SHALL have mismatch_o (output, 1, one-cycle pulse) and err_cnt_o (output, 8, mismatch count).

Function
REQ-012 Packing SHALL place element (i,j) at bits [k*DW +: DW], where k = TILE*TILE-1-(i*TILE+j), on all tile buses; result bits above TILE*TILE*DW SHALL be 0.
REQ-013 A PE beat SHALL be accepted when pe_valid_i and pe_ready_o are both high, and SHALL be pushed into a DEPTH-entry FIFO with its address.
REQ-014 pe_ready_o SHALL equal (count<DEPTH) and SHALL not depend on same-cycle pops; when full, no push occurs even if a pop occurs.
REQ-015 mem_ready_o SHALL equal (count>0) and (result register empty or result_ready_i).
REQ-016 An accepted memory beat with mem_addr_i equal to the FIFO head address SHALL pop the head and load the result register with element-wise head+mem sums, with result_addr_o = head address.
REQ-017 An accepted memory beat whose address does not match SHALL be discarded, SHALL leave the FIFO head intact, SHALL pulse mismatch_o for one cycle and SHALL increment err_cnt_o, saturating at 255.
REQ-018 The result register SHALL have states EMPTY and FULL: EMPTY->FULL on a match; FULL->EMPTY on result_ready_i with no match; FULL->FULL with new data on result_ready_i together with a match; FULL SHALL hold data stable while result_ready_i is low.
REQ-019 result_valid_o SHALL be high exactly in state FULL.
REQ-020 Latency SHALL be: PE accept at cycle t gives earliest mem accept at t+1; mem accept at cycle c gives result_valid_o at c+1.
REQ-021 A simultaneous push and pop SHALL leave count unchanged; FIFO pointers SHALL wrap modulo DEPTH.
REQ-022 The adder SHALL be DW+1 bits wide per element, with the output reduced per REQ-026.

Reset
REQ-023 While rst_n is low, the block SHALL empty the FIFO and set the result register to EMPTY, with result_o=0, result_addr_o=0, result_valid_o=0, mismatch_o=0, err_cnt_o=0, pe_ready_o=1 and mem_ready_o=0.
REQ-024 Reset asserted mid-operation SHALL discard all pending tiles and any unaccepted result, with no partial output.

Configuration
REQ-025 Macro CIM_ACCUM_SAT_EN SHALL select the overflow handling.
REQ-026 With CIM_ACCUM_SAT_EN defined, each sum SHALL clamp to [-2^(DW-1), 2^(DW-1)-1]; without it, each sum SHALL wrap modulo 2^DW (low DW bits).

Verification
REQ-027 Basic match: PE tile all 5 at addr 0x10, then mem all 7 at addr 0x10 -> one cycle later result_valid_o=1, all elements 12, result_addr_o=0x10, upper 80 bits 0.
REQ-028 Overflow: elements 2047+1 -> result 2047 with CIM_ACCUM_SAT_EN, -2048 without; -2048+(-1) -> -2048 with it, 2047 without.
REQ-029 Mismatch: head addr 0x03 and mem addr 0x04 -> mismatch_o pulses, err_cnt_o=1, head retained; mem addr 0x03 next -> match; 300 mismatches -> err_cnt_o=255.
REQ-030 Backpressure: push 4 tiles (pe_ready_o falls to 0), hold result_ready_i=0 -> result held stable and mem_ready_o=0; release -> 4 results in order, one per cycle.
REQ-031 Reset mid-run: 2 tiles pending and result FULL, pulse rst_n low asynchronously -> all outputs immediately at reset values; a later mem beat is not accepted.
